// File: rtl/scene_pkg.sv
// Shared screen encodings, glyph constants and slot field-width helpers for scene_controller.
package scene_pkg;

    typedef enum logic [1:0] {
        SCR_TITLE  = 2'b00,
        SCR_MENU   = 2'b01,
        SCR_PLAY   = 2'b10,
        SCR_RESULT = 2'b11
    } screen_t;

    localparam int GLYPH_W = 5;
    localparam int COMBO_W = 8;

    localparam logic [GLYPH_W-1:0] GLYPH_CURSOR = 5'b00100;
    localparam logic [GLYPH_W-1:0] GLYPH_TITLE  = 5'b01100;

    // Total width of a per-slot bus carrying n_obj notes plus the cursor slot.
    function automatic int slot_bits(input int n_obj, input int field_w);
        return (n_obj + 1) * field_w;
    endfunction

    // Screen x of note slot `slot` (1-based) before the scroll offset is added.
    function automatic int note_x(input int x_base, input int spacing, input int slot);
        return x_base + (slot - 1) * spacing;
    endfunction

endpackage

// File: rtl/scene_controller_scroll_timer.sv
// Scroll divider, xoffset down-counter and step pulse; runs only while enabled, sync load.
module scroll_timer #(
    parameter int XW         = 9,
    parameter int SPACING    = 48,
    parameter int SCROLL_DIV = 833333
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          load,
    output logic [XW-1:0] xoffset,
    output logic          step,
    output logic          step_evt
);

    localparam int DW = $clog2(SCROLL_DIV);
    localparam logic [XW-1:0] X_RELOAD = XW'(SPACING - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCROLL_DIV - 1);

    logic [DW-1:0] divider;
    logic          tick;

    assign tick     = en && !load && (divider == DIV_LAST);
    // Combinational so the judge can see the step on the same edge as the pre-step xoffset.
    assign step_evt = tick && (xoffset == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            divider <= '0;
            xoffset <= X_RELOAD;
            step    <= 1'b0;
        end else begin
            step <= step_evt;
            if (load) begin
                divider <= '0;
                xoffset <= X_RELOAD;
            end else if (en) begin
                if (tick) begin
                    divider <= '0;
                    xoffset <= (xoffset == '0) ? X_RELOAD : xoffset - XW'(1);
                end else begin
                    divider <= divider + DW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/scene_controller.sv
// Screen FSM, lead-note hit judge, score and registered per-slot draw mux.
// Optional SCENE_COMBO_EN: combo counter with double score while combo >= 8.
module scene_controller
    import scene_pkg::*;
#(
    parameter int NUM_OBJ     = 5,
    parameter int POSW        = 17,
    parameter int XW          = 9,
    parameter int X_BASE      = 64,
    parameter int SPACING     = 48,
    parameter int SCROLL_DIV  = 833333,
    parameter int HIT_WIN     = 8,
    parameter int ROUND_STEPS = 64,
    parameter int SCORE_W     = 8
) (
    input  logic                                 CLOCK_50,
    input  logic                                 reset,
    input  logic                                 key_any,
    input  logic                                 start_req,
    input  logic [NUM_OBJ*GLYPH_W-1:0]           note_in,
    input  logic [slot_bits(NUM_OBJ,GLYPH_W)-1:0] menu_draw,
    input  logic [slot_bits(NUM_OBJ,POSW)-1:0]    menu_pos,
    output logic [1:0]                           screen,
    output logic [slot_bits(NUM_OBJ,GLYPH_W)-1:0] draw,
    output logic [slot_bits(NUM_OBJ,POSW)-1:0]    pos,
    output logic [XW-1:0]                        xoffset,
    output logic                                 step,
    output logic                                 hit,
    output logic                                 miss,
    output logic [SCORE_W-1:0]                   score,
    output logic [COMBO_W-1:0]                   combo
);

    localparam int SCW = $clog2(ROUND_STEPS + 1);
    localparam int SW1 = SCORE_W + 1;
    localparam logic [SCW-1:0] LAST_STEP = SCW'(ROUND_STEPS - 1);

    screen_t        state;
    logic           key_prev, start_prev;
    logic           key_rise, start_rise;
    logic           in_play, load;
    logic           consumed;
    logic [SCW-1:0] step_cnt;
    logic           step_evt;
    logic           lead, hit_now, miss_now, bonus;
    logic [SW1-1:0] score_sum;
    logic [SCORE_W-1:0] score_next;

    logic [slot_bits(NUM_OBJ,GLYPH_W)-1:0] draw_next;
    logic [slot_bits(NUM_OBJ,POSW)-1:0]    pos_next;

    assign screen     = state;
    assign key_rise   = key_any && !key_prev;
    assign start_rise = start_req && !start_prev;
    assign in_play    = (state == SCR_PLAY);
    assign load       = (state == SCR_MENU) && start_rise;

    scroll_timer #(
        .XW         (XW),
        .SPACING    (SPACING),
        .SCROLL_DIV (SCROLL_DIV)
    ) u_scroll (
        .clk      (CLOCK_50),
        .reset    (reset),
        .en       (in_play),
        .load     (load),
        .xoffset  (xoffset),
        .step     (step),
        .step_evt (step_evt)
    );

`ifdef SCENE_COMBO_EN
    logic [COMBO_W-1:0] combo_q;
    assign combo = combo_q;
    assign bonus = (combo_q >= COMBO_W'(8));
`else
    assign combo = '0;
    assign bonus = 1'b0;
`endif

    // A key hit is judged against the pre-step xoffset and suppresses the step miss.
    assign lead     = (note_in[GLYPH_W-1:0] != '0) && !consumed;
    assign hit_now  = in_play && key_rise && lead && (int'(xoffset) <= HIT_WIN);
    assign miss_now = in_play && !hit_now && (key_rise || (step_evt && lead));

    assign score_sum  = {1'b0, score} + (bonus ? SW1'(2) : SW1'(1));
    assign score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= SCR_TITLE;
            key_prev   <= 1'b0;
            start_prev <= 1'b0;
            consumed   <= 1'b0;
            step_cnt   <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            score      <= '0;
`ifdef SCENE_COMBO_EN
            combo_q    <= '0;
`endif
        end else begin
            key_prev   <= key_any;
            start_prev <= start_req;
            hit        <= hit_now;
            miss       <= miss_now;
            unique case (state)
                SCR_TITLE: begin
                    if (key_rise) state <= SCR_MENU;
                end
                SCR_MENU: begin
                    if (start_rise) begin
                        state    <= SCR_PLAY;
                        score    <= '0;
                        step_cnt <= '0;
                        consumed <= 1'b0;
`ifdef SCENE_COMBO_EN
                        combo_q  <= '0;
`endif
                    end
                end
                SCR_PLAY: begin
                    if (hit_now) begin
                        score    <= score_next;
                        consumed <= 1'b1;
                    end
`ifdef SCENE_COMBO_EN
                    if (hit_now) begin
                        if (combo_q != '1) combo_q <= combo_q + COMBO_W'(1);
                    end else if (miss_now) begin
                        combo_q <= '0;
                    end
`endif
                    if (step_evt) begin
                        consumed <= 1'b0;
                        step_cnt <= step_cnt + SCW'(1);
                        if (step_cnt == LAST_STEP) state <= SCR_RESULT;
                    end
                end
                SCR_RESULT: begin
                    if (key_rise) state <= SCR_TITLE;
                end
                default: state <= SCR_TITLE;
            endcase
        end
    end

    always_comb begin
        draw_next = '0;
        pos_next  = '0;
        for (int unsigned i = 0; i <= NUM_OBJ; i++) begin
            unique case (state)
                SCR_TITLE: draw_next[i*GLYPH_W +: GLYPH_W] = GLYPH_TITLE;
                SCR_MENU: begin
                    draw_next[i*GLYPH_W +: GLYPH_W] = menu_draw[i*GLYPH_W +: GLYPH_W];
                    pos_next[i*POSW +: POSW]        = menu_pos[i*POSW +: POSW];
                end
                SCR_PLAY: begin
                    if (i == 0) begin
                        draw_next[GLYPH_W-1:0] = GLYPH_CURSOR;
                    end else begin
                        draw_next[i*GLYPH_W +: GLYPH_W] = note_in[(i-1)*GLYPH_W +: GLYPH_W];
                        pos_next[i*POSW +: POSW] =
                            POSW'(note_x(X_BASE, SPACING, int'(i)) + int'(xoffset));
                    end
                end
                SCR_RESULT: begin
                    if (i == 0) draw_next[GLYPH_W-1:0] = GLYPH_CURSOR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            draw <= '0;
            pos  <= '0;
        end else begin
            draw <= draw_next;
            pos  <= pos_next;
        end
    end

endmodule

// File: tb/tb_scene_controller.sv
// Self-checking bench for scene_controller: vector table, directed corner sequences,
// and randomized stimulus against a cycle-count based reference model.
module tb_scene_controller;

    localparam int NOBJ = 5;
    localparam int PW   = 17;
    localparam int XWD  = 9;
    localparam int XB   = 64;
    localparam int SP   = 48;
    localparam int DIV  = 4;
    localparam int HW   = 8;
    localparam int RS   = 10;
    localparam int SW   = 8;
    localparam int DWID = (NOBJ + 1) * 5;
    localparam int PWID = (NOBJ + 1) * PW;
`ifdef SCENE_COMBO_EN
    localparam bit COMBO = 1'b1;
`else
    localparam bit COMBO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            key_any = 1'b0;
    logic            start_req = 1'b0;
    logic [NOBJ*5-1:0] note_in = '0;
    logic [DWID-1:0] menu_draw = '0;
    logic [PWID-1:0] menu_pos = '0;
    logic [1:0]      screen;
    logic [DWID-1:0] draw;
    logic [PWID-1:0] pos;
    logic [XWD-1:0]  xoffset;
    logic            step, hit, miss;
    logic [SW-1:0]   score;
    logic [7:0]      combo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scene_controller #(
        .NUM_OBJ     (NOBJ),
        .POSW        (PW),
        .XW          (XWD),
        .X_BASE      (XB),
        .SPACING     (SP),
        .SCROLL_DIV  (DIV),
        .HIT_WIN     (HW),
        .ROUND_STEPS (RS),
        .SCORE_W     (SW)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .key_any   (key_any),
        .start_req (start_req),
        .note_in   (note_in),
        .menu_draw (menu_draw),
        .menu_pos  (menu_pos),
        .screen    (screen),
        .draw      (draw),
        .pos       (pos),
        .xoffset   (xoffset),
        .step      (step),
        .hit       (hit),
        .miss      (miss),
        .score     (score),
        .combo     (combo)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: scroll position derived from the number of PLAY cycles elapsed.
    int  m_scr = 0, m_n = 0, m_xoff = SP - 1, m_steps = 0, m_score = 0, m_combo = 0;
    bit  m_kprev = 0, m_sprev = 0, m_cons = 0, m_step = 0, m_hit = 0, m_miss = 0;
    logic [DWID-1:0] m_draw = '0;
    logic [PWID-1:0] m_pos = '0;

    always @(posedge clk) begin
        bit kr, sr, lead, tick_e, step_e;
        int t, gain;
        if (reset) begin
            m_scr = 0; m_n = 0; m_xoff = SP - 1; m_steps = 0; m_score = 0; m_combo = 0;
            m_kprev = 0; m_sprev = 0; m_cons = 0; m_step = 0; m_hit = 0; m_miss = 0;
            m_draw = '0; m_pos = '0;
        end else begin
            kr = key_any && !m_kprev;
            sr = start_req && !m_sprev;
            m_draw = '0;
            m_pos  = '0;
            for (int i = 0; i <= NOBJ; i++) begin
                case (m_scr)
                    0: m_draw[i*5 +: 5] = 5'b01100;
                    1: begin
                        m_draw[i*5 +: 5] = menu_draw[i*5 +: 5];
                        m_pos[i*PW +: PW] = menu_pos[i*PW +: PW];
                    end
                    2: if (i == 0) m_draw[4:0] = 5'b00100;
                       else begin
                           m_draw[i*5 +: 5] = note_in[(i-1)*5 +: 5];
                           m_pos[i*PW +: PW] = PW'(XB + (i - 1) * SP + m_xoff);
                       end
                    default: if (i == 0) m_draw[4:0] = 5'b00100;
                endcase
            end
            m_step = 0; m_hit = 0; m_miss = 0;
            case (m_scr)
                0: if (kr) m_scr = 1;
                1: if (sr) begin
                    m_scr = 2; m_score = 0; m_combo = 0; m_steps = 0; m_cons = 0;
                    m_n = 0; m_xoff = SP - 1;
                end
                2: begin
                    m_n++;
                    tick_e = (m_n % DIV) == 0;
                    t = m_n / DIV;
                    step_e = tick_e && (t % SP) == 0;
                    lead = (note_in[4:0] != 0) && !m_cons;
                    if (kr && lead && m_xoff <= HW) begin
                        m_hit = 1; m_cons = 1;
                        gain = (COMBO && m_combo >= 8) ? 2 : 1;
                        m_score = (m_score + gain > (1 << SW) - 1) ? (1 << SW) - 1 : m_score + gain;
                        if (COMBO && m_combo < 255) m_combo++;
                    end else if (kr || (step_e && lead)) begin
                        m_miss = 1; m_combo = 0;
                    end
                    m_xoff = SP - 1 - (t % SP);
                    if (step_e) begin
                        m_step = 1; m_cons = 0; m_steps++;
                        if (m_steps == RS) m_scr = 3;
                    end
                end
                default: if (kr) m_scr = 0;
            endcase
            m_kprev = key_any;
            m_sprev = start_req;
        end
    end

    always @(negedge clk) begin
        chk("m_screen", screen, m_scr);
        chk("m_draw", draw, m_draw);
        chk("m_pos", pos, m_pos);
        chk("m_xoffset", xoffset, m_xoff);
        chk("m_step", step, m_step);
        chk("m_hit", hit, m_hit);
        chk("m_miss", miss, m_miss);
        chk("m_score", score, m_score);
        chk("m_combo", combo, m_combo);
    end

    task automatic press();
        key_any = 1'b1;
        @(negedge clk);
        key_any = 1'b0;
    endtask

    task automatic wait_xoff(input int v, input int limit);
        int k = 0;
        while (int'(xoffset) != v && k < limit) begin @(negedge clk); k++; end
        chk("wait_xoff", xoffset, v);
    endtask

    task automatic wait_step(input int limit, output bit saw_miss);
        int k = 0;
        saw_miss = 0;
        while (step !== 1'b1 && k < limit) begin
            @(negedge clk); k++;
            if (miss) saw_miss = 1;
        end
        chk("wait_step", step, 1);
    endtask

    task automatic wait_screen(input int v, input int limit);
        int k = 0;
        while (int'(screen) != v && k < limit) begin @(negedge clk); k++; end
        chk("wait_screen", screen, v);
    endtask

    typedef struct {
        bit rst, key, start;
        int exp_screen, exp_score, exp_xoff;
    } vec_t;

    initial begin
        vec_t vecs[11];
        int cnt, xo;
        bit sm;

        vecs = '{
            '{1, 0, 0, 0, 0, 47}, '{1, 0, 0, 0, 0, 47}, '{0, 0, 0, 0, 0, 47},
            '{0, 1, 0, 1, 0, 47}, '{0, 1, 0, 1, 0, 47}, '{0, 0, 0, 1, 0, 47},
            '{0, 0, 1, 2, 0, 47}, '{0, 0, 1, 2, 0, 47}, '{0, 0, 0, 2, 0, 47},
            '{0, 0, 0, 2, 0, 47}, '{0, 0, 0, 2, 0, 46}
        };
        for (int i = 0; i < 11; i++) begin
            reset = vecs[i].rst; key_any = vecs[i].key; start_req = vecs[i].start;
            @(negedge clk);
            chk("vec_screen", screen, vecs[i].exp_screen);
            chk("vec_score", score, vecs[i].exp_score);
            chk("vec_xoff", xoffset, vecs[i].exp_xoff);
            if (i < 2) begin
                chk("rst_draw", draw, 0);
                chk("rst_pos", pos, 0);
            end
        end

        // Scroll period, draw latency and step pulse.
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (xoffset == 46 && cnt < 10);
        chk("tick_period", cnt, 4);
        chk("xoff_dec", xoffset, 45);
        chk("slot2_pos_old", pos[2*PW +: PW], 112 + 46);
        @(negedge clk);
        chk("slot2_pos_new", pos[2*PW +: PW], 112 + 45);
        wait_step(300, sm);
        chk("step_reload", xoffset, 47);
        @(negedge clk);
        chk("step_one_cycle", step, 0);

        // Hit inside the window, no step miss afterwards.
        note_in = 25'd1;
        wait_xoff(5, 400);
        press();
        chk("hit5_hit", hit, 1);
        chk("hit5_miss", miss, 0);
        chk("hit5_score", score, 1);
        wait_step(300, sm);
        chk("no_step_miss", sm, 0);

        // Key outside the window is a miss.
        wait_xoff(20, 300);
        press();
        chk("miss20_miss", miss, 1);
        chk("miss20_hit", hit, 0);
        chk("miss20_score", score, 1);

        // Key rise on the step edge at xoffset 0.
        wait_xoff(0, 300);
        repeat (3) @(negedge clk);
        press();
        chk("coinc_hit", hit, 1);
        chk("coinc_miss", miss, 0);
        chk("coinc_step", step, 1);
        chk("coinc_xoff", xoffset, 47);
        chk("coinc_score", score, 2);
        wait_xoff(3, 300);
        press();
        chk("after_coinc_hit", hit, 1);
        chk("after_coinc_score", score, 3);

        // Round end and RESULT hold.
        wait_screen(3, 4000);
        chk("result_score", score, 3);
        xo = int'(xoffset);
        repeat (20) @(negedge clk);
        chk("result_frozen", xoffset, xo);
        chk("result_held", score, 3);
        press();
        chk("result_to_title", screen, 0);

        // Second round: combo behaviour.
        @(negedge clk);
        press();
        chk("title_to_menu", screen, 1);
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        chk("round2_screen", screen, 2);
        chk("round2_score", score, 0);
        chk("round2_xoff", xoffset, 47);
        for (int k = 0; k < 9; k++) begin
            wait_xoff(5, 300);
            press();
            chk("combo_hit", hit, 1);
            wait_step(300, sm);
        end
        chk("nine_hits_score", score, COMBO ? 10 : 9);
        chk("nine_hits_combo", combo, COMBO ? 9 : 0);
        wait_xoff(20, 300);
        press();
        chk("combo_miss", miss, 1);
        chk("combo_cleared", combo, 0);
        wait_screen(3, 4000);
        press();
        chk("round2_title", screen, 0);

        // Randomized phase, checked by the model.
        repeat (4000) begin
            key_any   = ($urandom_range(0, 3) == 0);
            start_req = ($urandom_range(0, 7) == 0);
            note_in   = 25'($urandom());
            if ($urandom_range(0, 1) == 1) note_in[4:0] = '0;
            menu_draw = 30'($urandom());
            menu_pos  = PWID'({$urandom(), $urandom(), $urandom(), $urandom()});
            reset     = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end

        // Reset in the middle of PLAY.
        key_any = 0; start_req = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        press();
        @(negedge clk);
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        note_in = 25'd1;
        chk("final_play", screen, 2);
        wait_xoff(5, 400);
        press();
        chk("final_score", score, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midplay_rst_screen", screen, 0);
        chk("midplay_rst_score", score, 0);
        chk("midplay_rst_xoff", xoffset, 47);
        reset = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
